// File: rtl/accel_spi_pkg.sv
// rtl/accel_spi_pkg.sv - shared register map, FSM states and helpers for the accelerometer SPI responder
package accel_spi_pkg;

  localparam logic [5:0] ADDR_DEVID       = 6'h00;
  localparam logic [5:0] ADDR_INT_ENABLE  = 6'h2E;
  localparam logic [5:0] ADDR_INT_SOURCE  = 6'h30;
  localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [5:0] ADDR_DATAX0      = 6'h32;
  localparam logic [5:0] ADDR_DATAX1      = 6'h33;
  localparam logic [5:0] ADDR_DATAY0      = 6'h34;
  localparam logic [5:0] ADDR_DATAY1      = 6'h35;
  localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
  localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

  // INT_SOURCE bit carrying DATA_READY; INT_ENABLE uses the same position
  localparam int DATA_READY_BIT = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WRITE = 2'd2,
    READ  = 2'd3
  } spi_state_t;

  // Axis sample bytes; reading any of them acknowledges DATA_READY
  function automatic logic is_data_addr(input logic [5:0] a);
    return (a >= ADDR_DATAX0) && (a <= ADDR_DATAZ1);
  endfunction

  // Addresses the SPI master may not overwrite
  function automatic logic is_ro_addr(input logic [5:0] a);
    return (a == ADDR_DEVID) || (a == ADDR_INT_SOURCE) || is_data_addr(a);
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// rtl/spi_edge_sync.sv - multi-flop input synchronizer with rise/fall pulse detection
module spi_edge_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the pad value through the synchronizer and keep one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= STAGES'({sync_q, din});
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/accel_spi_responder.sv
// rtl/accel_spi_responder.sv - SPI mode-3 register responder for a 3-axis accelerometer
module accel_spi_responder
  import accel_spi_pkg::*;
#(
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_sdat_in,
  output logic        spi_sdat_out,
  output logic        spi_sdat_oe,
  output logic        spi_int,
  input  logic        sample_valid,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z
);

  // Cycles after reset during which a cs_n fall is an artefact of the synchronizer preset
  localparam logic [3:0] ARM_CYCLES = 4'(SYNC_STAGES + 1);

  logic sclk_q, sclk_rise, sclk_fall;
  logic cs_q, cs_rise, cs_fall;
  logic sdat_q, sdat_rise, sdat_fall;

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
    .clk(clk_clk), .rst_n(reset_reset_n), .din(spi_sclk),
    .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk_clk), .rst_n(reset_reset_n), .din(spi_cs_n),
    .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdat (
    .clk(clk_clk), .rst_n(reset_reset_n), .din(spi_sdat_in),
    .q(sdat_q), .rise(sdat_rise), .fall(sdat_fall)
  );

  logic unused_sync;
  assign unused_sync = sclk_q ^ sdat_rise ^ sdat_fall;

  spi_state_t  state;
  logic [2:0]  bit_cnt;
  logic [7:0]  rx_sh;
  logic [7:0]  tx_sh;
  logic [5:0]  addr;
  logic        mb;
  logic [3:0]  arm_cnt;

  logic [7:0]  regs [0:63];
  logic        data_ready;
  logic        pend_valid;
  logic [15:0] pend_x, pend_y, pend_z;

  // Register view seen by the master; DEVID and INT_SOURCE are synthesised, not stored
  function automatic logic [7:0] read_reg(input logic [5:0] a);
    logic [7:0] v;
    v = regs[a];
    if (a == ADDR_DEVID) begin
      v = DEVID;
    end else if (a == ADDR_INT_SOURCE) begin
      v = 8'h00;
      v[DATA_READY_BIT] = data_ready;
    end
    return v;
  endfunction

  logic [7:0] rx_byte;
  logic [5:0] next_addr;
  logic       byte_done;
  logic [7:0] cmd_rd_byte;
  logic [7:0] next_rd_byte;
  logic       wr_en;
  logic       rd_clr;
  logic       armed;
  logic       load_pend;
  logic       load_direct;
  logic       hold_sample;

  assign rx_byte      = {rx_sh[6:0], sdat_q};
  assign next_addr    = mb ? (addr + 6'd1) : addr;
  assign byte_done    = sclk_rise && (bit_cnt == 3'd7) && !cs_rise;
  assign cmd_rd_byte  = read_reg(rx_byte[5:0]);
  assign next_rd_byte = read_reg(next_addr);
  assign wr_en        = (state == WRITE) && byte_done && !is_ro_addr(addr);
  assign rd_clr       = (state == READ) && byte_done && is_data_addr(addr);
  assign armed        = (arm_cnt == ARM_CYCLES);
  // A sample arriving while the master is selected is parked so a burst read sees one coherent set
  assign load_pend    = cs_rise && pend_valid;
  assign load_direct  = sample_valid && cs_q;
  assign hold_sample  = sample_valid && !cs_q;

  // Transaction FSM: command decode, byte shifting and pad drive
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state        <= IDLE;
      bit_cnt      <= 3'd0;
      rx_sh        <= 8'h00;
      tx_sh        <= 8'h00;
      addr         <= 6'd0;
      mb           <= 1'b0;
      arm_cnt      <= 4'd0;
      spi_sdat_oe  <= 1'b0;
      spi_sdat_out <= 1'b0;
    end else begin
      if (!armed) arm_cnt <= arm_cnt + 4'd1;
      if (cs_rise) begin
        state        <= IDLE;
        bit_cnt      <= 3'd0;
        spi_sdat_oe  <= 1'b0;
        spi_sdat_out <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall && armed) begin
              state   <= CMD;
              bit_cnt <= 3'd0;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              rx_sh   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                addr <= rx_byte[5:0];
                mb   <= rx_byte[6];
                if (rx_byte[7]) begin
                  state        <= READ;
                  tx_sh        <= cmd_rd_byte;
                  spi_sdat_out <= cmd_rd_byte[7];
                  spi_sdat_oe  <= 1'b1;
                end else begin
                  state <= WRITE;
                end
              end
            end
          end
          WRITE: begin
            if (sclk_rise) begin
              rx_sh   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) addr <= next_addr;
            end
          end
          READ: begin
            // bit7 is already on the pad at byte start, so the first fall re-drives it
            if (sclk_fall) begin
              spi_sdat_out <= tx_sh[7];
              tx_sh        <= {tx_sh[6:0], 1'b0};
            end
            if (sclk_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                addr  <= next_addr;
                tx_sh <= next_rd_byte;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Register storage, sample capture, DATA_READY tracking and the interrupt output
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < 64; i++) regs[i] <= 8'h00;
      data_ready <= 1'b0;
      pend_valid <= 1'b0;
      pend_x     <= 16'h0000;
      pend_y     <= 16'h0000;
      pend_z     <= 16'h0000;
      spi_int    <= 1'b0;
    end else begin
      if (wr_en) regs[addr] <= rx_byte;
      if (load_pend) begin
        regs[ADDR_DATAX0] <= pend_x[7:0];
        regs[ADDR_DATAX1] <= pend_x[15:8];
        regs[ADDR_DATAY0] <= pend_y[7:0];
        regs[ADDR_DATAY1] <= pend_y[15:8];
        regs[ADDR_DATAZ0] <= pend_z[7:0];
        regs[ADDR_DATAZ1] <= pend_z[15:8];
      end
      if (load_direct) begin
        regs[ADDR_DATAX0] <= sample_x[7:0];
        regs[ADDR_DATAX1] <= sample_x[15:8];
        regs[ADDR_DATAY0] <= sample_y[7:0];
        regs[ADDR_DATAY1] <= sample_y[15:8];
        regs[ADDR_DATAZ0] <= sample_z[7:0];
        regs[ADDR_DATAZ1] <= sample_z[15:8];
      end
      if (hold_sample) begin
        pend_x     <= sample_x;
        pend_y     <= sample_y;
        pend_z     <= sample_z;
        pend_valid <= 1'b1;
      end else if (load_pend) begin
        pend_valid <= 1'b0;
      end
      if (load_pend || load_direct) data_ready <= 1'b1;
      else if (rd_clr)              data_ready <= 1'b0;
      spi_int <= data_ready & regs[ADDR_INT_ENABLE][DATA_READY_BIT];
    end
  end

endmodule

// File: tb/tb_accel_spi_responder.sv
// tb/tb_accel_spi_responder.sv - scoreboard bench for the accelerometer SPI responder
module tb_accel_spi_responder;

  localparam int HALF = 8;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        spi_sclk;
  logic        spi_cs_n;
  logic        spi_sdat_in;
  logic        spi_sdat_out;
  logic        spi_sdat_oe;
  logic        spi_int;
  logic        sample_valid;
  logic [15:0] sample_x, sample_y, sample_z;

  always #5 clk_clk = ~clk_clk;

  accel_spi_responder dut (
    .clk_clk(clk_clk),
    .reset_reset_n(reset_reset_n),
    .spi_sclk(spi_sclk),
    .spi_cs_n(spi_cs_n),
    .spi_sdat_in(spi_sdat_in),
    .spi_sdat_out(spi_sdat_out),
    .spi_sdat_oe(spi_sdat_oe),
    .spi_int(spi_int),
    .sample_valid(sample_valid),
    .sample_x(sample_x),
    .sample_y(sample_y),
    .sample_z(sample_z)
  );

  string      tag_q[$];
  logic [7:0] val_q[$];
  logic       obs_valid = 1'b0;
  logic [7:0] obs_data  = 8'h00;
  int         check_cnt = 0;
  int         pass_cnt  = 0;

  task automatic expect_val(input string tag, input logic [7:0] v);
    tag_q.push_back(tag);
    val_q.push_back(v);
  endtask

  task automatic observe(input logic [7:0] v);
    @(posedge clk_clk); #1;
    obs_data  = v;
    obs_valid = 1'b1;
    @(posedge clk_clk); #1;
    obs_valid = 1'b0;
  endtask

  always @(negedge clk_clk) begin : monitor
    string      t;
    logic [7:0] e;
    if (obs_valid) begin
      check_cnt++;
      if (val_q.size() == 0) begin
        $display("FAIL unexpected_obs got=%02h exp=none", obs_data);
      end else begin
        t = tag_q.pop_front();
        e = val_q.pop_front();
        if (obs_data === e) pass_cnt++;
        else $display("FAIL %s got=%02h exp=%02h", t, obs_data, e);
      end
    end
  end

  task automatic spi_bits(input logic [7:0] tx, input int nbits,
                          output logic [7:0] rx, output logic oe_all, output logic oe_any);
    rx = 8'h00; oe_all = 1'b1; oe_any = 1'b0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_sclk    = 1'b0;
      spi_sdat_in = tx[i];
      repeat (HALF) @(posedge clk_clk); #1;
      rx[i]  = spi_sdat_out;
      oe_all = oe_all & spi_sdat_oe;
      oe_any = oe_any | spi_sdat_oe;
      spi_sclk = 1'b1;
      repeat (HALF) @(posedge clk_clk); #1;
    end
  endtask

  task automatic spi_start();
    spi_cs_n = 1'b0;
    repeat (HALF) @(posedge clk_clk); #1;
  endtask

  task automatic spi_stop();
    spi_cs_n = 1'b1;
    repeat (HALF) @(posedge clk_clk); #1;
    expect_val("oe_idle", 8'h00);
    observe({7'b0, spi_sdat_oe});
  endtask

  task automatic cmd_byte(input logic [7:0] cmd);
    logic [7:0] rx; logic oa, oy;
    expect_val("oe_cmd", 8'h00);
    spi_bits(cmd, 8, rx, oa, oy);
    observe({7'b0, oy});
  endtask

  task automatic rd_byte(input logic [7:0] e);
    logic [7:0] rx; logic oa, oy;
    expect_val("rd_data", e);
    expect_val("oe_rd", 8'h01);
    spi_bits(8'h00, 8, rx, oa, oy);
    observe(rx);
    observe({7'b0, oa});
  endtask

  task automatic wr_byte(input logic [7:0] d);
    logic [7:0] rx; logic oa, oy;
    expect_val("oe_wr", 8'h00);
    spi_bits(d, 8, rx, oa, oy);
    observe({7'b0, oy});
  endtask

  // Expected bytes are left-aligned: first byte in bits 47:40
  task automatic rd_txn(input logic [7:0] cmd, input int n, input logic [47:0] e);
    spi_start();
    cmd_byte(cmd);
    for (int k = 0; k < n; k++) rd_byte(e[47-8*k -: 8]);
    spi_stop();
  endtask

  task automatic wr_txn(input logic [7:0] cmd, input int n, input logic [23:0] d);
    spi_start();
    cmd_byte(cmd);
    for (int k = 0; k < n; k++) wr_byte(d[23-8*k -: 8]);
    spi_stop();
  endtask

  task automatic sample_pulse(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(posedge clk_clk); #1;
    sample_x = x; sample_y = y; sample_z = z;
    sample_valid = 1'b1;
    @(posedge clk_clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic check_int(input logic e);
    expect_val("spi_int", {7'b0, e});
    observe({7'b0, spi_int});
  endtask

  initial begin
    logic [7:0] rx; logic oa, oy;
    reset_reset_n = 1'b0;
    spi_cs_n      = 1'b1;
    spi_sclk      = 1'b1;
    spi_sdat_in   = 1'b0;
    sample_valid  = 1'b0;
    sample_x = 16'h0; sample_y = 16'h0; sample_z = 16'h0;
    repeat (3) @(posedge clk_clk); #1;

    // reset state
    expect_val("rst_oe", 8'h00);  observe({7'b0, spi_sdat_oe});
    expect_val("rst_out", 8'h00); observe({7'b0, spi_sdat_out});
    expect_val("rst_int", 8'h00); observe({7'b0, spi_int});
    reset_reset_n = 1'b1;
    repeat (HALF) @(posedge clk_clk); #1;

    // DEVID single-byte read
    rd_txn(8'h80, 1, 48'hE5_0000000000);

    // enable interrupt, load a sample, interrupt follows within two cycles
    wr_txn(8'h2E, 1, 24'h80_0000);
    sample_pulse(16'h1234, 16'h0000, 16'h0000);
    @(posedge clk_clk); #1;
    check_int(1'b1);
    rd_txn(8'hAE, 1, 48'h80_0000000000);
    rd_txn(8'hB0, 1, 48'h80_0000000000);

    // burst read of all axis bytes clears DATA_READY and the interrupt
    sample_pulse(16'h1234, 16'hFFFE, 16'h0100);
    rd_txn(8'hF2, 6, 48'h3412_FEFF_0001);
    check_int(1'b0);
    rd_txn(8'hB0, 1, 48'h00_0000000000);

    // burst write across the top of the map; 0x00 is read-only
    wr_txn(8'h7E, 3, 24'hA1A2A3);
    rd_txn(8'hFE, 3, 48'hA1A2E5_000000);
    rd_txn(8'hBE, 2, 48'hA1A1_00000000);

    // samples during an active burst read are deferred; the newest one wins
    spi_start();
    cmd_byte(8'hF2);
    rd_byte(8'h34);
    sample_pulse(16'h1111, 16'h2222, 16'h3333);
    sample_pulse(16'h5678, 16'h9ABC, 16'hDEF0);
    rd_byte(8'h12);
    rd_byte(8'hFE);
    rd_byte(8'hFF);
    rd_byte(8'h00);
    rd_byte(8'h01);
    spi_stop();
    check_int(1'b1);
    rd_txn(8'hF2, 6, 48'h7856_BC9A_F0DE);
    check_int(1'b0);

    // reset mid-write to DATA_FORMAT, then SCLK with cs_n still low is ignored
    spi_start();
    cmd_byte(8'h31);
    spi_bits(8'hFF, 4, rx, oa, oy);
    reset_reset_n = 1'b0;
    repeat (2) @(posedge clk_clk); #1;
    expect_val("abort_oe", 8'h00); observe({7'b0, spi_sdat_oe});
    reset_reset_n = 1'b1;
    repeat (2) @(posedge clk_clk); #1;
    expect_val("ignore_oe", 8'h00);
    spi_bits(8'hFF, 8, rx, oa, oy);
    observe({7'b0, oy});
    expect_val("ignore_oe_after", 8'h00); observe({7'b0, spi_sdat_oe});
    spi_stop();
    rd_txn(8'hB1, 1, 48'h00_0000000000);
    rd_txn(8'hAE, 1, 48'h00_0000000000);
    rd_txn(8'hBE, 1, 48'h00_0000000000);
    check_int(1'b0);
    wr_txn(8'h31, 1, 24'h0B_0000);
    rd_txn(8'hB1, 1, 48'h0B_0000000000);

    repeat (4) @(posedge clk_clk); #1;
    while (val_q.size() > 0) begin
      check_cnt++;
      $display("FAIL missing_%s got=none exp=%02h", tag_q.pop_front(), val_q.pop_front());
    end
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/accel_spi_responder.md
ACCEL_SPI_RESPONDER -- requirements
Module: accel_spi_responder

Interface
REQ-001 Parameter DEVID, default 8'hE5, value returned by register 0x00.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth for sclk/cs_n/sdat_in.
REQ-003 clk_clk  input  1  system clock; all logic on its rising edge; the design requires clk_clk >= 8x SCLK.
REQ-004 reset_reset_n  input  1  asynchronous, active-low reset.
REQ-005 spi_sclk  input  1  SPI clock from the master; idles high (CPOL=1, CPHA=1).
REQ-006 spi_cs_n  input  1  chip select, active low.
REQ-007 spi_sdat_in  input  1  bidirectional data line sensed from the pad.
REQ-008 spi_sdat_out  output  1  data driven onto the pad when spi_sdat_oe=1.
REQ-009 spi_sdat_oe  output  1  pad output enable.
REQ-010 spi_int  output  1  interrupt, active high.
REQ-011 sample_valid  input  1  one-cycle strobe qualifying sample_x/y/z.
REQ-012 sample_x, sample_y, sample_z  input  16 each  signed two's-complement axis samples.

Function
REQ-013 The block SHALL pass spi_sclk, spi_cs_n and spi_sdat_in through SYNC_STAGES flops, then detect SCLK edges from the synchronized copy.
REQ-014 The register file SHALL be 64x8: 0x00 = DEVID (RO); 0x2E = INT_ENABLE (RW); 0x30 = INT_SOURCE (RO, bit7 = DATA_READY); 0x31 = DATA_FORMAT (RW); 0x32-0x37 = X/Y/Z low/high bytes (RO). All other addresses SHALL be RW scratch.
REQ-015 The FSM SHALL use states IDLE, CMD, WRITE, READ.
REQ-016 IDLE->CMD SHALL occur on the falling edge of synchronized cs_n.
REQ-017 In CMD, 8 bits SHALL be sampled MSB-first on SCLK rising edges: bit7 = R/W (1 = read), bit6 = MB, bits5:0 = address.
REQ-018 After the 8th bit, the FSM SHALL go to READ if R/W=1, otherwise WRITE.
REQ-019 In WRITE, each 8 sampled bits SHALL be committed to the current address on the 8th rising edge. Writes to RO addresses SHALL be discarded.
REQ-020 In READ, the byte at the current address SHALL be latched on entry and after each byte.
REQ-021 In READ, spi_sdat_out SHALL present that byte MSB-first, updating on SCLK falling edges, with spi_sdat_oe=1 throughout READ.
REQ-022 The first read bit SHALL be valid before the first falling edge following the command byte.
REQ-023 After each data byte, the address SHALL increment if MB=1, wrapping 0x3F->0x00. If MB=0, the address SHALL hold.
REQ-024 A rising edge of cs_n in any state SHALL return the FSM to IDLE within 1 cycle, set oe=0, and discard any partial byte.
REQ-025 sample_valid SHALL load X/Y/Z into 0x32-0x37 (low byte at the even address) and set DATA_READY.
REQ-026 If cs_n is low when sample_valid arrives, the sample SHALL be held in a one-deep pending buffer and applied on the cycle cs_n rises. A newer sample SHALL overwrite the pending one.
REQ-027 Completing a read of any byte in 0x32-0x37 SHALL clear DATA_READY. If a set and a clear occur in the same cycle, set wins.
REQ-028 spi_int SHALL equal DATA_READY AND INT_ENABLE[7], registered (1-cycle latency).

Reset
REQ-029 On reset_reset_n=0, the block SHALL asynchronously go to state IDLE with spi_sdat_oe=0, spi_sdat_out=0, spi_int=0, all RW registers = 0x00, data registers = 0x00, DATA_READY=0, pending buffer empty, and synchronizers preset to idle (sclk=1, cs_n=1).
REQ-030 Reset asserted mid-transaction SHALL abort the transaction. After release, the block SHALL ignore SCLK activity until the next cs_n falling edge.

Structure
REQ-031 Register addresses, the state enumeration and the INT_SOURCE bit index SHALL live in a shared package, accel_spi_pkg.
REQ-032 The synchronizer/edge detector SHALL be the sub-module spi_edge_sync, instantiated once per input.

Verification
REQ-033 Read 0x00 single byte (cmd 0x80) -> 8'hE5 on sdat, oe high only during the data byte.
REQ-034 Write 0x2E=0x80 (cmd 0x2E), then sample_valid with x=0x1234 -> spi_int=1 within 2 cycles; a read of 0x2E returns 0x80.
REQ-035 Multi-byte read from 0x32 (cmd 0xF2, 6 bytes) after x=0x1234, y=0xFFFE, z=0x0100 -> 34 12 FE FF 00 01; DATA_READY and spi_int clear.
REQ-036 Multi-byte write starting at 0x3E with 3 bytes A1 A2 A3 -> 0x3E=A1, 0x3F=A2, 0x00 unchanged (RO), address wraps.
REQ-037 sample_valid during an active read -> read data unchanged; new values appear after cs_n rises.
REQ-038 Reset pulse after 4 bits of a write to 0x31 -> 0x31 stays 0x00 and oe=0; the next transaction works normally.
